// File: rtl/source_sequencer_if.sv
// Word stream from the source sequencer into the packet streamer.
interface source_sequencer_if;
  logic [15:0] source_data;
  logic        source_en;
  logic        source_packet_end;

  modport master (output source_data, output source_en, output source_packet_end);
  modport slave  (input  source_data, input  source_en, input  source_packet_end);
endinterface

// File: rtl/source_sequencer.sv
// Packet-aligned sequencer packing quantized/raw ADC samples into 16-bit streamer words.
// Define SOURCE_SEQ_TEST_PATTERN_EN to make mode 4 (word counter test pattern) legal.
module source_sequencer #(
  parameter int GROUPS_PER_PACKET = 240
) (
  input  logic        source_clk,
  input  logic        source_reset,
  input  logic        enable,
  input  logic [7:0]  mode,
  input  logic [1:0]  ch1_si,
  input  logic [1:0]  ch1_sq,
  input  logic [1:0]  ch2_si,
  input  logic [1:0]  ch2_sq,
  input  logic [1:0]  ch3_si,
  input  logic [1:0]  ch3_sq,
  input  logic [7:0]  ch1_i,
  input  logic [7:0]  ch1_q,
  source_sequencer_if.master src,
  output logic        busy,
  output logic [7:0]  active_mode,
  output logic [15:0] packet_count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] G_LAST = 8'(GROUPS_PER_PACKET - 1);

  state_t      state;
  state_t      state_next;
  logic [1:0]  ph;
  logic [7:0]  g;
  logic [11:0] s_cur;
  logic [11:0] s_prev;
  logic [7:0]  i_prev;
  logic [7:0]  q_prev;
  logic        mode_ok;
  logic        last_word;
  logic        start;
  logic        restart;
  logic        word_en;
  logic [15:0] word_data;
  logic [15:0] data_q;
  logic        en_q;
  logic        end_q;

`ifdef SOURCE_SEQ_TEST_PATTERN_EN
  logic [15:0] tp_count;
`endif

  function automatic logic mode_legal(input logic [7:0] m);
`ifdef SOURCE_SEQ_TEST_PATTERN_EN
    return m <= 8'd4;
`else
    return m <= 8'd3;
`endif
  endfunction

  assign s_cur     = {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};
  assign mode_ok   = mode_legal(mode);
  assign last_word = (state == RUN) && (ph == 2'd3) && (g == G_LAST);
  assign start     = (state == IDLE) && enable && mode_ok;
  assign restart   = last_word && enable && mode_ok;

  always_ff @(posedge source_clk or posedge source_reset) begin
    if (source_reset) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable && mode_ok) state_next = RUN;
      RUN:  if (last_word && !(enable && mode_ok)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Each word combines the previous cycle's sample with the one presented now.
  always_comb begin
    word_en   = 1'b0;
    word_data = 16'd0;
    if (state == RUN) begin
      case (active_mode)
        8'd0: begin
          word_en = (ph != 2'd0);
          case (ph)
            2'd1:    word_data = {s_prev, s_cur[11:8]};
            2'd2:    word_data = {s_prev[7:0], s_cur[11:4]};
            2'd3:    word_data = {s_prev[3:0], s_cur};
            default: word_data = 16'd0;
          endcase
        end
        8'd1: begin
          word_en = ph[0];
          if (ph[0]) word_data = {i_prev, ch1_i};
        end
        8'd2: begin
          word_en = ph[0];
          if (ph[0]) word_data = {q_prev, ch1_q};
        end
        8'd3: begin
          word_en = ph[0];
          if (ph[0]) word_data = {ch1_i, ch1_q};
        end
`ifdef SOURCE_SEQ_TEST_PATTERN_EN
        8'd4: begin
          word_en = (ph != 2'd0);
          if (ph != 2'd0) word_data = tp_count;
        end
`endif
        default: begin
          word_en   = 1'b0;
          word_data = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge source_clk or posedge source_reset) begin
    if (source_reset) begin
      ph     <= 2'd0;
      g      <= 8'd0;
      s_prev <= 12'd0;
      i_prev <= 8'd0;
      q_prev <= 8'd0;
    end else begin
      s_prev <= s_cur;
      i_prev <= ch1_i;
      q_prev <= ch1_q;
      if (state == RUN && !last_word) begin
        ph <= ph + 2'd1;
        if (ph == 2'd3) g <= g + 8'd1;
      end else begin
        ph <= 2'd0;
        g  <= 8'd0;
      end
    end
  end

  always_ff @(posedge source_clk or posedge source_reset) begin
    if (source_reset) begin
      data_q       <= 16'd0;
      en_q         <= 1'b0;
      end_q        <= 1'b0;
      busy         <= 1'b0;
      active_mode  <= 8'd0;
      packet_count <= 16'd0;
    end else begin
      data_q <= word_data;
      en_q   <= word_en;
      end_q  <= last_word;
      busy   <= (state_next == RUN);
      if (start || restart) active_mode <= mode;
      if (last_word) packet_count <= packet_count + 16'd1;
    end
  end

`ifdef SOURCE_SEQ_TEST_PATTERN_EN
  // Pattern restarts from zero at every packet start, including back-to-back ones.
  always_ff @(posedge source_clk or posedge source_reset) begin
    if (source_reset)          tp_count <= 16'd0;
    else if (start || restart) tp_count <= 16'd0;
    else if (word_en)          tp_count <= tp_count + 16'd1;
  end
`endif

  assign src.source_data       = data_q;
  assign src.source_en         = en_q;
  assign src.source_packet_end = end_q;

endmodule

// File: tb/tb_source_sequencer.sv
// Directed bench for source_sequencer with GROUPS_PER_PACKET=2; expected words are hand-computed.
module tb_source_sequencer;

  logic        source_clk = 1'b0;
  logic        source_reset;
  logic        enable;
  logic [7:0]  mode;
  logic [1:0]  ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq;
  logic [7:0]  ch1_i, ch1_q;
  logic        busy;
  logic [7:0]  active_mode;
  logic [15:0] packet_count;

  int checks = 0;
  int passes = 0;

  source_sequencer_if src ();

  source_sequencer #(.GROUPS_PER_PACKET(2)) dut (
    .source_clk   (source_clk),
    .source_reset (source_reset),
    .enable       (enable),
    .mode         (mode),
    .ch1_si       (ch1_si),
    .ch1_sq       (ch1_sq),
    .ch2_si       (ch2_si),
    .ch2_sq       (ch2_sq),
    .ch3_si       (ch3_si),
    .ch3_sq       (ch3_sq),
    .ch1_i        (ch1_i),
    .ch1_q        (ch1_q),
    .src          (src.master),
    .busy         (busy),
    .active_mode  (active_mode),
    .packet_count (packet_count)
  );

  always #5 source_clk = ~source_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else             passes++;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic applyStimulus(input logic en, input logic [7:0] md, input logic [11:0] sv,
                               input logic [7:0] iv, input logic [7:0] qv);
    enable = en;
    mode   = md;
    {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq} = sv;
    ch1_i  = iv;
    ch1_q  = qv;
    @(posedge source_clk);
    #1;
  endtask

  task automatic check_cycle(input string tag, input int k, input logic [15:0] ed,
                             input logic ee, input logic ep, input logic eb);
    checkOutput($sformatf("%s_data_k%0d", tag, k), 32'(src.source_data), 32'(ed));
    checkOutput($sformatf("%s_en_k%0d", tag, k), 32'(src.source_en), 32'(ee));
    checkOutput($sformatf("%s_end_k%0d", tag, k), 32'(src.source_packet_end), 32'(ep));
    checkOutput($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(eb));
  endtask

  logic [11:0] s_pat   [4] = '{12'hABC, 12'h123, 12'h456, 12'h789};
  logic [15:0] m0_word [4] = '{16'h0000, 16'hABC1, 16'h2345, 16'h6789};
  logic [15:0] m1_word [8] = '{16'h0, 16'h0001, 16'h0, 16'h0203, 16'h0, 16'h0405, 16'h0, 16'h0607};
  logic [15:0] m2_word [8] = '{16'h0, 16'hF0F1, 16'h0, 16'hF2F3, 16'h0, 16'hF4F5, 16'h0, 16'hF6F7};
  logic [15:0] m3_word [8] = '{16'h0, 16'h1989, 16'h0, 16'h1B8B, 16'h0, 16'h1D8D, 16'h0, 16'h1F8F};
  logic [15:0] tp_word [8] = '{16'h0, 16'h0000, 16'h0001, 16'h0002, 16'h0, 16'h0003, 16'h0004, 16'h0005};

  initial begin
    int en_hits;
    int busy_hits;
    source_reset = 1'b1;
    enable = 1'b0;
    mode = 8'd0;
    {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq} = 12'd0;
    ch1_i = 8'd0;
    ch1_q = 8'd0;
    repeat (2) @(posedge source_clk);
    #1;
    check_cycle("reset", 0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_active_mode", 32'(active_mode), 32'd0);
    checkOutput("reset_packet_count", 32'(packet_count), 32'd0);
    source_reset = 1'b0;

    $display("[TB] mode 0 packet");
    applyStimulus(1'b1, 8'd0, 12'h000, 8'h00, 8'h00);
    check_cycle("m0_start", 0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k != 7, 8'd0, s_pat[k % 4], 8'h00, 8'h00);
      check_cycle("m0", k, m0_word[k % 4], (k % 4) != 0, k == 7, k != 7);
    end
    checkOutput("m0_packet_count", 32'(packet_count), 32'd1);

    $display("[TB] mode 1 packet");
    applyStimulus(1'b1, 8'd1, 12'h000, 8'h00, 8'hAA);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k != 7, 8'd1, 12'hFFF, 8'(k), 8'hAA);
      check_cycle("m1", k, m1_word[k], k[0], k == 7, k != 7);
    end
    checkOutput("m1_packet_count", 32'(packet_count), 32'd2);
    checkOutput("m1_active_mode", 32'(active_mode), 32'd1);

    $display("[TB] mode 2 packet");
    applyStimulus(1'b1, 8'd2, 12'h000, 8'h55, 8'h00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k != 7, 8'd2, 12'h000, 8'h55, 8'(8'hF0 + k));
      check_cycle("m2", k, m2_word[k], k[0], k == 7, k != 7);
    end
    checkOutput("m2_packet_count", 32'(packet_count), 32'd3);

    $display("[TB] mode change 0 -> 3 mid-packet");
    applyStimulus(1'b1, 8'd0, 12'h000, 8'h00, 8'h00);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k != 15, (k >= 2) ? 8'd3 : 8'd0, s_pat[k % 4], 8'(8'h10 + k), 8'(8'h80 + k));
      if (k < 8) check_cycle("mchg_p1", k, m0_word[k % 4], (k % 4) != 0, k == 7, 1'b1);
      else       check_cycle("mchg_p2", k, m3_word[k - 8], k[0], k == 15, k != 15);
      if (k == 6) checkOutput("mchg_active_mode_old", 32'(active_mode), 32'd0);
      if (k == 7) begin
        checkOutput("mchg_active_mode_new", 32'(active_mode), 32'd3);
        checkOutput("mchg_count_p1", 32'(packet_count), 32'd4);
      end
    end
    checkOutput("mchg_count_p2", 32'(packet_count), 32'd5);

    $display("[TB] enable dropped after first word");
    applyStimulus(1'b1, 8'd0, 12'h000, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k < 2, 8'd0, s_pat[k % 4], 8'h00, 8'h00);
      check_cycle("edrop", k, m0_word[k % 4], (k % 4) != 0, k == 7, k != 7);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 8'd0, s_pat[k % 4], 8'h00, 8'h00);
      check_cycle("edrop_idle", k, 16'h0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("edrop_packet_count", 32'(packet_count), 32'd6);

    $display("[TB] illegal mode 9");
    en_hits = 0;
    busy_hits = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 8'd9, s_pat[k % 4], 8'(k), 8'(k));
      if (src.source_en) en_hits++;
      if (busy) busy_hits++;
    end
    checkOutput("illegal_en_cycles", 32'(en_hits), 32'd0);
    checkOutput("illegal_busy_cycles", 32'(busy_hits), 32'd0);
    checkOutput("illegal_active_mode", 32'(active_mode), 32'd0);

    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, 8'd0, 12'h000, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'd0, s_pat[k % 4], 8'h00, 8'h00);
    end
    checkOutput("rst_word3_before", 32'(src.source_data), 32'h6789);
    source_reset = 1'b1;
    #1;
    check_cycle("rst_async", 0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_async_active_mode", 32'(active_mode), 32'd0);
    checkOutput("rst_async_packet_count", 32'(packet_count), 32'd0);
    @(posedge source_clk);
    #1;
    source_reset = 1'b0;
    applyStimulus(1'b1, 8'd1, 12'h000, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k != 7, 8'd1, 12'h000, 8'(k), 8'h00);
      check_cycle("rst_m1", k, m1_word[k], k[0], k == 7, k != 7);
    end
    checkOutput("rst_packet_count", 32'(packet_count), 32'd1);

`ifdef SOURCE_SEQ_TEST_PATTERN_EN
    $display("[TB] mode 4 test pattern");
    applyStimulus(1'b1, 8'd4, 12'h000, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k != 7, 8'd4, 12'hFFF, 8'hFF, 8'hFF);
      check_cycle("m4", k, tp_word[k], (k % 4) != 0, k == 7, k != 7);
    end
    checkOutput("m4_packet_count", 32'(packet_count), 32'd2);
`else
    $display("[TB] mode 4 without test pattern");
    en_hits = 0;
    busy_hits = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 8'd4, s_pat[k % 4], 8'h00, 8'h00);
      if (src.source_en) en_hits++;
      if (busy) busy_hits++;
    end
    checkOutput("m4_off_en_cycles", 32'(en_hits), 32'd0);
    checkOutput("m4_off_busy_cycles", 32'(busy_hits), 32'd0);
    checkOutput("m4_off_packet_count", 32'(packet_count), 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
